toom8_recompose: RTL and testbench



---
 rtl/toom8_recompose.sv | 105 ++++++++++
 tb/tb_toom8_recompose.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/toom8_recompose.sv
// Serial Toom-8 recomposition: accumulates c_k << (CHUNK_W*k) over a valid/ready
// coefficient stream and presents the OUT_W-bit product with a sticky overflow flag.
module toom8_recompose #(
    parameter int CHUNK_W  = 128,
    parameter int NUM_COEF = 15,
    parameter int COEF_W   = 260,
    parameter int OUT_W    = 2048
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              coef_valid,
    output logic              coef_ready,
    input  logic [COEF_W-1:0] coef_data,
    output logic              product_valid,
    input  logic              product_ready,
    output logic [OUT_W-1:0]  product,
    output logic              overflow
);
    // state | meaning
    // ACCUM | accepting coefficient idx, adding it into acc at weight 2^(CHUNK_W*idx)
    // HOLD  | product complete, held stable until product_ready

    localparam int IDX_W = (NUM_COEF > 1) ? $clog2(NUM_COEF) : 1;
    localparam int EXT_W = OUT_W + 4;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] idx;
    logic [OUT_W-1:0] acc;
    logic             ovf;

    logic             beat;
    logic             last_beat;
    logic             release_hold;
    logic [31:0]      shamt;
    logic [EXT_W-1:0] coef_ext;
    logic [EXT_W-1:0] addend;
    logic [OUT_W:0]   sum;
    logic             addend_hi;
    logic             ovf_beat;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ACCUM:   if (beat && last_beat) state_nxt = HOLD;
            HOLD:    if (product_ready)     state_nxt = ACCUM;
            default: state_nxt = ACCUM;
        endcase
    end

    always_comb begin
        coef_ready    = 1'b0;
        product_valid = 1'b0;
        unique case (state)
            ACCUM:   coef_ready    = 1'b1;
            HOLD:    product_valid = 1'b1;
            default: coef_ready    = 1'b0;
        endcase
    end

    assign beat         = coef_valid && coef_ready;
    assign release_hold = product_valid && product_ready;
    assign last_beat    = (idx == IDX_W'(NUM_COEF - 1));

    // The addend is kept 4 bits wider than acc so bits shifted past OUT_W stay
    // visible to the overflow detect instead of silently dropping.
    assign coef_ext  = EXT_W'(coef_data);
    assign shamt     = 32'(CHUNK_W) * 32'(idx);
    assign addend    = coef_ext << shamt;
    assign sum       = {1'b0, acc} + {1'b0, addend[OUT_W-1:0]};
    assign addend_hi = |addend[EXT_W-1:OUT_W];
    assign ovf_beat  = addend_hi | sum[OUT_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= '0;
            acc <= '0;
            ovf <= 1'b0;
        end else if (beat) begin
            acc <= sum[OUT_W-1:0];
            ovf <= ovf | ovf_beat;
            idx <= last_beat ? '0 : idx + 1'b1;
        end else if (release_hold) begin
            acc <= '0;
            ovf <= 1'b0;
        end
    end

    assign product  = acc;
    assign overflow = ovf;

endmodule

// File: tb/tb_toom8_recompose.sv
// Directed bench for toom8_recompose: fixed coefficient frames with hand-derived
// products, backpressure on both sides, overflow and mid-frame reset.
module tb_toom8_recompose;
    localparam int CHUNK_W  = 128;
    localparam int NUM_COEF = 15;
    localparam int COEF_W   = 260;
    localparam int OUT_W    = 2048;

    logic              clk;
    logic              rst;
    logic              coef_valid;
    logic              coef_ready;
    logic [COEF_W-1:0] coef_data;
    logic              product_valid;
    logic              product_ready;
    logic [OUT_W-1:0]  product;
    logic              overflow;

    int n_checks;
    int n_errors;

    logic [COEF_W-1:0] frame [NUM_COEF];
    logic [OUT_W-1:0]  ones_exp;
    logic [OUT_W-1:0]  sq_exp;
    logic [OUT_W-1:0]  carry_exp;
    logic [OUT_W-1:0]  held;
    logic [1023:0]     a_op;
    int                cyc;
    int                lat;

    toom8_recompose #(
        .CHUNK_W  (CHUNK_W),
        .NUM_COEF (NUM_COEF),
        .COEF_W   (COEF_W),
        .OUT_W    (OUT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .coef_valid    (coef_valid),
        .coef_ready    (coef_ready),
        .coef_data     (coef_data),
        .product_valid (product_valid),
        .product_ready (product_ready),
        .product       (product),
        .overflow      (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [OUT_W-1:0] got,
                             input logic [OUT_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h (low 128 bits)", tag, got[127:0], exp[127:0]);
        end
    endtask

    task automatic fill_frame(input logic [COEF_W-1:0] v);
        for (int i = 0; i < NUM_COEF; i++) frame[i] = v;
    endtask

    // Presents frame[0..n-1]; with gaps set, coef_valid is high every other cycle.
    task automatic send_frame(input int n, input bit gaps, output int cycles);
        int k;
        bit tog;
        bit beat;
        k = 0;
        tog = 1'b1;
        cycles = 0;
        while (k < n && cycles < 200) begin
            coef_valid = gaps ? tog : 1'b1;
            coef_data  = frame[k];
            @(negedge clk);
            beat = coef_valid && coef_ready;
            @(posedge clk); #1;
            cycles++;
            if (beat) k++;
            tog = !tog;
        end
        coef_valid = 1'b0;
        if (k < n) check_val("send_timeout", OUT_W'(k), OUT_W'(n));
    endtask

    task automatic wait_valid(output int l);
        l = 0;
        @(negedge clk);
        while (!product_valid && l < 50) begin
            @(negedge clk);
            l++;
        end
    endtask

    task automatic release_result();
        product_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        coef_valid = 1'b0;
        coef_data = '0;
        product_ready = 1'b0;

        ones_exp  = {128'd0, {15{128'd1}}};
        carry_exp = (2048'd1 << 256) + (2048'd1 << 128) - 2048'd1;
        a_op = {128'd8, 128'd7, 128'd6, 128'd5, 128'd4, 128'd3, 128'd2, 128'd253};
        sq_exp = OUT_W'(a_op) * OUT_W'(a_op);

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_product", product, '0);
        check_val("rst_valid", OUT_W'(product_valid), '0);
        check_val("rst_overflow", OUT_W'(overflow), '0);
        check_val("rst_coef_ready", OUT_W'(coef_ready), OUT_W'(1));
        @(posedge clk); #1;
        rst = 1'b0;

        // All ones, back to back, consumer always ready
        product_ready = 1'b1;
        fill_frame(260'd1);
        send_frame(15, 1'b0, cyc);
        check_val("ones_cycles", OUT_W'(cyc), OUT_W'(15));
        wait_valid(lat);
        check_val("ones_latency", OUT_W'(lat), '0);
        check_val("ones_valid", OUT_W'(product_valid), OUT_W'(1));
        check_val("ones_product", product, ones_exp);
        check_val("ones_overflow", OUT_W'(overflow), '0);
        @(posedge clk); #1;
        @(negedge clk);
        check_val("ones_valid_drop", OUT_W'(product_valid), '0);
        check_val("ones_ready_back", OUT_W'(coef_ready), OUT_W'(1));
        @(posedge clk); #1;

        // Squaring of A = {8,7,6,5,4,3,2,253} (limb 7 .. limb 0)
        frame[0]  = 260'd64009; frame[1]  = 260'd1012; frame[2]  = 260'd1522;
        frame[3]  = 260'd2036;  frame[4]  = 260'd2555; frame[5]  = 260'd3080;
        frame[6]  = 260'd3612;  frame[7]  = 260'd4152; frame[8]  = 260'd147;
        frame[9]  = 260'd164;   frame[10] = 260'd170;  frame[11] = 260'd164;
        frame[12] = 260'd145;   frame[13] = 260'd112;  frame[14] = 260'd64;
        send_frame(15, 1'b0, cyc);
        wait_valid(lat);
        check_val("sq_valid", OUT_W'(product_valid), OUT_W'(1));
        check_val("sq_product", product, sq_exp);
        check_val("sq_overflow", OUT_W'(overflow), '0);
        release_result();

        // Carry ripple across the limb boundary
        fill_frame('0);
        frame[0] = (260'd1 << 256) - 260'd1;
        frame[1] = 260'd1;
        send_frame(15, 1'b0, cyc);
        wait_valid(lat);
        check_val("carry_product", product, carry_exp);
        check_val("carry_overflow", OUT_W'(overflow), '0);
        release_result();

        // Top coefficient spills past OUT_W
        fill_frame('0);
        frame[14] = 260'd1 << 256;
        send_frame(15, 1'b0, cyc);
        wait_valid(lat);
        check_val("ovf_product", product, '0);
        check_val("ovf_flag", OUT_W'(overflow), OUT_W'(1));
        release_result();
        fill_frame('0);
        send_frame(15, 1'b0, cyc);
        wait_valid(lat);
        check_val("ovf_cleared", OUT_W'(overflow), '0);
        check_val("zero_product", product, '0);
        release_result();

        // Source backpressure: valid every other cycle
        fill_frame(260'd1);
        send_frame(15, 1'b1, cyc);
        check_val("gap_cycles", OUT_W'(cyc), OUT_W'(29));
        wait_valid(lat);
        check_val("gap_product", product, ones_exp);
        check_val("gap_overflow", OUT_W'(overflow), '0);
        release_result();

        // Consumer backpressure: hold for 10 cycles with stray coef_valid pulses
        product_ready = 1'b0;
        send_frame(15, 1'b0, cyc);
        wait_valid(lat);
        check_val("bp_valid", OUT_W'(product_valid), OUT_W'(1));
        held = product;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            coef_valid = (i % 2 == 0);
            coef_data  = 260'd5;
            @(negedge clk);
            check_val("bp_stable", product, held);
            check_val("bp_coef_ready", OUT_W'(coef_ready), '0);
            check_val("bp_valid_held", OUT_W'(product_valid), OUT_W'(1));
        end
        @(posedge clk); #1;
        coef_valid = 1'b0;
        product_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check_val("bp_ready_back", OUT_W'(coef_ready), OUT_W'(1));
        check_val("bp_cleared", product, '0);
        @(posedge clk); #1;
        send_frame(15, 1'b0, cyc);
        wait_valid(lat);
        check_val("bp_next_product", product, ones_exp);
        release_result();

        // Reset mid-frame discards the partial sum
        fill_frame(260'd3);
        send_frame(7, 1'b0, cyc);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_val("midrst_product", product, '0);
        @(posedge clk); #1;
        fill_frame(260'd1);
        send_frame(15, 1'b0, cyc);
        wait_valid(lat);
        check_val("midrst_latency", OUT_W'(lat), '0);
        check_val("midrst_product_final", product, ones_exp);
        check_val("midrst_overflow", OUT_W'(overflow), '0);
        release_result();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
